cache_port_scheduler: RTL and testbench

Registered, state-machine scheduler that shares the single L2 cache line port between the I-cache and D-cache miss paths. I-cache misses have priority, but a starvation counter guarantees the D-cache a grant after a bounded number of consecutive I-cache grants. All L2-side outputs and both cache-side response/data outputs come from flops, so no combinational path runs from L2 back to either L1.

---
 rtl/cache_port_scheduler.sv | 144 ++++++++++++++
 tb/tb_cache_port_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_scheduler.sv
// Shares the single L2 line port between the I-cache and D-cache miss paths.
// I-cache has priority; a saturating starvation counter forces a D-cache grant.
module cache_port_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  ipmem_address,
  input  logic         ipmem_read,
  input  logic         ipmem_write,
  input  logic [255:0] ipmem_wdata,
  output logic [255:0] ipmem_rdata,
  output logic         ipmem_resp,
  input  logic [31:0]  dpmem_address,
  input  logic         dpmem_read,
  input  logic         dpmem_write,
  input  logic [255:0] dpmem_wdata,
  output logic [255:0] dpmem_rdata,
  output logic         dpmem_resp,
  output logic [31:0]  l2mem_address,
  output logic         l2mem_read,
  output logic         l2mem_write,
  output logic [255:0] l2mem_wdata,
  input  logic [255:0] l2mem_rdata,
  input  logic         l2mem_resp,
  output logic         busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [LW-1:0] irdata_q, irdata_d;
  logic [LW-1:0] drdata_q, drdata_d;
  logic          iresp_q, iresp_d;
  logic          dresp_q, dresp_d;
  logic          busy_q, busy_d;
  logic          i_req, d_req;

  assign i_req = ipmem_read | ipmem_write;
  assign d_req = dpmem_read | dpmem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      iresp_q  <= 1'b0;
      dresp_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iresp_q  <= iresp_d;
      dresp_q  <= dresp_d;
      busy_q   <= busy_d;
    end
  end

  // Arbitration, L2 handshake and response generation.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iresp_d  = 1'b0;
    dresp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (starve_q == CW'(STARVE_LIMIT)))) begin
          state_d  = GRANT_D;
          addr_d   = dpmem_address;
          wdata_d  = dpmem_wdata;
          wr_d     = dpmem_write;
          rd_d     = dpmem_read & ~dpmem_write;
          starve_d = '0;
        end else if (i_req) begin
          state_d = GRANT_I;
          addr_d  = ipmem_address;
          wdata_d = ipmem_wdata;
          wr_d    = ipmem_write;
          rd_d    = ipmem_read & ~ipmem_write;
          if (d_req && (starve_q != {CW{1'b1}})) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2mem_resp) begin
          state_d = RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (state_q == GRANT_I) begin
            iresp_d = 1'b1;
            if (rd_q) irdata_d = l2mem_rdata;
          end else begin
            dresp_d = 1'b1;
            if (rd_q) drdata_d = l2mem_rdata;
          end
        end
      end
      RESP: begin
        // Forced IDLE cycle: a request still visible during resp is not re-served.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ipmem_rdata   = irdata_q;
  assign ipmem_resp    = iresp_q;
  assign dpmem_rdata   = drdata_q;
  assign dpmem_resp    = dresp_q;
  assign l2mem_address = addr_q;
  assign l2mem_read    = rd_q;
  assign l2mem_write   = wr_q;
  assign l2mem_wdata   = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cache_port_scheduler.sv
// Directed bench for cache_port_scheduler: hand-computed expectations per cycle.
module tb_cache_port_scheduler;

  logic         clk;
  logic         rst_n;
  logic [31:0]  ipmem_address, dpmem_address;
  logic         ipmem_read, ipmem_write, dpmem_read, dpmem_write;
  logic [255:0] ipmem_wdata, dpmem_wdata;
  logic [255:0] ipmem_rdata, dpmem_rdata;
  logic         ipmem_resp, dpmem_resp;
  logic [31:0]  l2mem_address;
  logic         l2mem_read, l2mem_write;
  logic [255:0] l2mem_wdata, l2mem_rdata;
  logic         l2mem_resp;
  logic         busy;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  cache_port_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ipmem_address(ipmem_address), .ipmem_read(ipmem_read), .ipmem_write(ipmem_write),
    .ipmem_wdata(ipmem_wdata), .ipmem_rdata(ipmem_rdata), .ipmem_resp(ipmem_resp),
    .dpmem_address(dpmem_address), .dpmem_read(dpmem_read), .dpmem_write(dpmem_write),
    .dpmem_wdata(dpmem_wdata), .dpmem_rdata(dpmem_rdata), .dpmem_resp(dpmem_resp),
    .l2mem_address(l2mem_address), .l2mem_read(l2mem_read), .l2mem_write(l2mem_write),
    .l2mem_wdata(l2mem_wdata), .l2mem_rdata(l2mem_rdata), .l2mem_resp(l2mem_resp),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] L69 = {32{8'h69}};
  localparam logic [255:0] L44 = {32{8'h44}};
  localparam logic [255:0] LA5 = {32{8'hA5}};
  localparam logic [255:0] L5A = {32{8'h5A}};
  localparam logic [255:0] L33 = {32{8'h33}};
  localparam logic [255:0] L3C = {32{8'h3C}};
  localparam logic [255:0] LFF = {256{1'b1}};

  logic [255:0] exp_ird, exp_drd;
  logic [5:0]   exp_is_d;
  int           n;

  initial begin
    rst_n = 1'b0;
    ipmem_address = '0; ipmem_read = 1'b0; ipmem_write = 1'b0; ipmem_wdata = '0;
    dpmem_address = '0; dpmem_read = 1'b0; dpmem_write = 1'b0; dpmem_wdata = '0;
    l2mem_rdata = '0; l2mem_resp = 1'b0;
    step(); step();
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_l2read", 256'(l2mem_read), 256'(0));
    check("rst_l2addr", 256'(l2mem_address), 256'(0));
    check("rst_irdata", ipmem_rdata, '0);
    rst_n = 1'b1;

    // Single I read, L2 answers in its second cycle.
    ipmem_read = 1'b1; ipmem_address = 32'h1111_1111;
    step();
    check("i1_l2read", 256'(l2mem_read), 256'(1));
    check("i1_l2addr", 256'(l2mem_address), 256'(32'h1111_1111));
    check("i1_busy", 256'(busy), 256'(1));
    step();
    check("i1_l2read_hold", 256'(l2mem_read), 256'(1));
    check("i1_iresp_early", 256'(ipmem_resp), 256'(0));
    l2mem_resp = 1'b1; l2mem_rdata = L69;
    step();
    check("i1_iresp", 256'(ipmem_resp), 256'(1));
    check("i1_irdata", ipmem_rdata, L69);
    check("i1_dresp", 256'(dpmem_resp), 256'(0));
    check("i1_l2read_drop", 256'(l2mem_read), 256'(0));
    l2mem_resp = 1'b0; ipmem_read = 1'b0;
    step();
    check("i1_iresp_pulse", 256'(ipmem_resp), 256'(0));
    check("i1_idle_busy", 256'(busy), 256'(0));

    // Simultaneous I and D reads: I first, then D after RESP+IDLE.
    ipmem_read = 1'b1; dpmem_read = 1'b1;
    dpmem_address = 32'hdddd_dddd;
    step();
    check("sim_addr_i", 256'(l2mem_address), 256'(32'h1111_1111));
    l2mem_resp = 1'b1; l2mem_rdata = L69;
    step();
    check("sim_iresp", 256'(ipmem_resp), 256'(1));
    check("sim_irdata", ipmem_rdata, L69);
    check("sim_gap1", 256'(l2mem_read), 256'(0));
    l2mem_resp = 1'b0; ipmem_read = 1'b0;
    step();
    check("sim_gap2", 256'(l2mem_read), 256'(0));
    step();
    check("sim_l2read_d", 256'(l2mem_read), 256'(1));
    check("sim_addr_d", 256'(l2mem_address), 256'(32'hdddd_dddd));
    l2mem_resp = 1'b1; l2mem_rdata = L44;
    step();
    check("sim_dresp", 256'(dpmem_resp), 256'(1));
    check("sim_drdata", dpmem_rdata, L44);
    check("sim_iresp_quiet", 256'(ipmem_resp), 256'(0));
    check("sim_irdata_kept", ipmem_rdata, L69);
    l2mem_resp = 1'b0; dpmem_read = 1'b0;
    step();

    // Starvation: four I grants, then D, then I resumes.
    exp_is_d = 6'b01_0000;
    exp_ird = L69; exp_drd = L44;
    ipmem_read = 1'b1; dpmem_read = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin step(); n++; end while (!l2mem_read && n < 8);
      check("stv_grant_seen", 256'(l2mem_read), 256'(1));
      check($sformatf("stv_winner%0d", t), 256'(l2mem_address),
            exp_is_d[t] ? 256'(32'hdddd_dddd) : 256'(32'h1111_1111));
      l2mem_resp = 1'b1;
      l2mem_rdata = exp_is_d[t] ? L33 : L5A;
      step();
      l2mem_resp = 1'b0;
      if (exp_is_d[t]) exp_drd = L33; else exp_ird = L5A;
      check($sformatf("stv_iresp%0d", t), 256'(ipmem_resp), 256'(!exp_is_d[t]));
      check($sformatf("stv_dresp%0d", t), 256'(dpmem_resp), 256'(exp_is_d[t]));
      if (exp_is_d[t]) dpmem_read = 1'b0;
    end
    ipmem_read = 1'b0;
    check("stv_drdata", dpmem_rdata, exp_drd);
    check("stv_irdata", ipmem_rdata, exp_ird);
    step();

    // D write: rdata must not change.
    dpmem_write = 1'b1; dpmem_wdata = LA5; dpmem_address = 32'hdddd_dde0;
    step();
    check("dw_l2write", 256'(l2mem_write), 256'(1));
    check("dw_l2read", 256'(l2mem_read), 256'(0));
    check("dw_wdata", l2mem_wdata, LA5);
    check("dw_addr", 256'(l2mem_address), 256'(32'hdddd_dde0));
    step();
    check("dw_hold", 256'(l2mem_write), 256'(1));
    l2mem_resp = 1'b1; l2mem_rdata = LFF;
    step();
    check("dw_dresp", 256'(dpmem_resp), 256'(1));
    check("dw_drdata_kept", dpmem_rdata, exp_drd);
    check("dw_write_drop", 256'(l2mem_write), 256'(0));
    l2mem_resp = 1'b0; dpmem_write = 1'b0;
    step();
    check("dw_dresp_pulse", 256'(dpmem_resp), 256'(0));

    // Requester drops after grant: access still completes.
    ipmem_read = 1'b1; ipmem_address = 32'h2222_2220;
    step();
    ipmem_read = 1'b0;
    step();
    check("drop_hold1", 256'(l2mem_read), 256'(1));
    step();
    check("drop_hold2", 256'(l2mem_read), 256'(1));
    l2mem_resp = 1'b1; l2mem_rdata = L5A;
    step();
    check("drop_iresp", 256'(ipmem_resp), 256'(1));
    check("drop_irdata", ipmem_rdata, L5A);
    l2mem_resp = 1'b0;
    step();

    // Reset while in GRANT_D.
    dpmem_read = 1'b1; dpmem_address = 32'hdddd_0000;
    step();
    check("rm_busy", 256'(busy), 256'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; dpmem_read = 1'b0;
    check("rm_busy0", 256'(busy), 256'(0));
    check("rm_l2read", 256'(l2mem_read), 256'(0));
    check("rm_l2addr", 256'(l2mem_address), 256'(0));
    check("rm_irdata", ipmem_rdata, '0);
    check("rm_drdata", dpmem_rdata, '0);
    l2mem_resp = 1'b1; l2mem_rdata = L44;
    step();
    l2mem_resp = 1'b0;
    check("rm_stray_d", 256'(dpmem_resp), 256'(0));
    check("rm_stray_i", 256'(ipmem_resp), 256'(0));
    step();
    check("rm_stray_d2", 256'(dpmem_resp), 256'(0));
    check("rm_stray_rdata", dpmem_rdata, '0);

    // Read and write together: write wins.
    ipmem_read = 1'b1; ipmem_write = 1'b1; ipmem_wdata = L3C; ipmem_address = 32'h3333_3340;
    step();
    check("rw_write", 256'(l2mem_write), 256'(1));
    check("rw_read", 256'(l2mem_read), 256'(0));
    check("rw_wdata", l2mem_wdata, L3C);
    l2mem_resp = 1'b1; l2mem_rdata = LFF;
    step();
    check("rw_iresp", 256'(ipmem_resp), 256'(1));
    check("rw_irdata_kept", ipmem_rdata, '0);
    l2mem_resp = 1'b0; ipmem_read = 1'b0; ipmem_write = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
